// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and helpers used by the system-bus masters and slaves.
package ahb_pkg;

  typedef enum logic [1:0] {
    RespOkay  = 2'b00,
    RespError = 2'b01,
    RespRetry = 2'b10,
    RespSplit = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } trans_e;

  typedef enum logic [2:0] {
    BurstSingle = 3'd0,
    BurstIncr   = 3'd1,
    BurstWrap4  = 3'd2,
    BurstIncr4  = 3'd3,
    BurstWrap8  = 3'd4,
    BurstIncr8  = 3'd5,
    BurstWrap16 = 3'd6,
    BurstIncr16 = 3'd7
  } burst_e;

  typedef enum logic [2:0] {
    SizeBits8    = 3'd0,
    SizeBits16   = 3'd1,
    SizeBits32   = 3'd2,
    SizeBits64   = 3'd3,
    SizeBits128  = 3'd4,
    SizeBits256  = 3'd5,
    SizeBits512  = 3'd6,
    SizeBits1024 = 3'd7
  } sizem_e;

  typedef enum logic {
    WrRdRead  = 1'b0,
    WrRdWrite = 1'b1
  } wr_rd_e;

  // Byte lanes touched by a transfer on a 32-bit little-endian data bus.
  function automatic logic [3:0] ahb_byte_en(logic [2:0] size, logic [1:0] addr);
    logic [3:0] en;
    case (size)
      SizeBits8:  en = 4'b0001 << addr;
      SizeBits16: en = addr[1] ? 4'b1100 : 4'b0011;
      default:    en = 4'b1111;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/ahb_sram_word.sv
// Word-organised RAM: asynchronous read, synchronous byte-enabled write, contents never reset.
module ahb_sram_word
  import ahb_pkg::*;
#(
  parameter int unsigned Words = 1024,
  parameter int unsigned AddrW = $clog2(Words)
) (
  input  logic             clk_i,
  input  logic [3:0]       we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [Words];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB memory slave answering the LCD DMA fetch path: wait-state insertion, legality checks
// and the two-cycle ERROR response in front of a word RAM.
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned AddrW    = $clog2(MEM_WORDS);
  localparam logic [32:0] EndAddr  = {1'b0, BASE_ADDR} + 33'(4 * MEM_WORDS);
  localparam logic [3:0]  WaitLoad = 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic        write_q;
  logic [2:0]  size_q;
  logic        legal_q;
  logic [3:0]  wait_q;
  logic [31:0] hrdata_q;

  logic        accept, legal, in_range, size_ok, aligned;
  logic        read_data, write_data;
  logic [31:0] offset;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;

  // HREADYOUT gating keeps a held address phase from being sampled twice.
  assign accept   = HSEL && HREADY && HREADYOUT &&
                    (HTRANS == TransNonseq || HTRANS == TransSeq);
  assign in_range = (HADDR >= BASE_ADDR) && ({1'b0, HADDR} < EndAddr);
  assign size_ok  = HSIZE <= SizeBits32;
  assign aligned  = (HSIZE == SizeBits16) ? !HADDR[0] :
                    (HSIZE == SizeBits32) ? (HADDR[1:0] == 2'b00) : 1'b1;
  assign legal    = in_range && size_ok && aligned;

  assign offset     = addr_q - BASE_ADDR;
  assign read_data  = (state_q == StData) && !write_q;
  // Reset in the commit cycle must abort the write.
  assign write_data = (state_q == StData) && write_q && legal_q && !HRESET;
  assign ram_we     = write_data ? ahb_byte_en(size_q, addr_q[1:0]) : 4'b0000;
  assign HRDATA     = read_data ? ram_rdata : hrdata_q;

  logic unused_bits;
  assign unused_bits = ^{offset[31:AddrW+2], offset[1:0], HBURST};

  ahb_sram_word #(
    .Words (MEM_WORDS)
  ) u_sram (
    .clk_i   (HCLK),
    .we_i    (ram_we),
    .addr_i  (offset[AddrW+1:2]),
    .wdata_i (HWDATA),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= StIdle;
      HREADYOUT <= 1'b1;
      HRESP     <= RespOkay;
      hrdata_q  <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= '0;
      legal_q   <= 1'b0;
      wait_q    <= '0;
    end else begin
      if (read_data) begin
        hrdata_q <= ram_rdata;
      end
      if (accept) begin
        addr_q  <= HADDR;
        write_q <= HWRITE;
        size_q  <= HSIZE;
        legal_q <= legal;
      end
      unique case (state_q)
        StIdle, StData, StErr2: begin
          if (accept && !legal) begin
            state_q   <= StErr1;
            HREADYOUT <= 1'b0;
            HRESP     <= RespError;
          end else if (accept && WAIT_STATES != 0) begin
            state_q   <= StWait;
            wait_q    <= WaitLoad;
            HREADYOUT <= 1'b0;
            HRESP     <= RespOkay;
          end else if (accept) begin
            state_q   <= StData;
            HREADYOUT <= 1'b1;
            HRESP     <= RespOkay;
          end else begin
            state_q   <= StIdle;
            HREADYOUT <= 1'b1;
            HRESP     <= RespOkay;
          end
        end
        StWait: begin
          HRESP <= RespOkay;
          if (wait_q == 4'd0) begin
            state_q   <= StData;
            HREADYOUT <= 1'b1;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        StErr1: begin
          state_q   <= StErr2;
          HREADYOUT <= 1'b1;
          HRESP     <= RespError;
        end
        default: begin
          state_q   <= StIdle;
          HREADYOUT <= 1'b1;
          HRESP     <= RespOkay;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: a zero-wait and a three-wait instance on a shared bus,
// random AHB traffic checked against an associative-array memory model.
module tb_ahb_mem_slave;
  import ahb_pkg::*;

  localparam logic [31:0] Base  = 32'h2000_0000;
  localparam int unsigned Words = 1024;

  logic        HCLK = 1'b0;
  logic        HRESET, hsel, HWRITE, ws3;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic        rdy0, rdy3, bus_ready;
  logic [1:0]  resp0, resp3, bus_resp;
  logic [31:0] rdata0, rdata3, bus_rdata;

  assign bus_ready = ws3 ? rdy3 : rdy0;
  assign bus_resp  = ws3 ? resp3 : resp0;
  assign bus_rdata = ws3 ? rdata3 : rdata0;

  ahb_mem_slave #(.BASE_ADDR(Base), .MEM_WORDS(Words), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel & ~ws3), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(bus_ready),
    .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0)
  );

  ahb_mem_slave #(.BASE_ADDR(Base), .MEM_WORDS(Words), .WAIT_STATES(3)) dut3 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel & ws3), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(bus_ready),
    .HREADYOUT(rdy3), .HRESP(resp3), .HRDATA(rdata3)
  );

  always #5 HCLK = ~HCLK;

  // kind: 0 transfer, 1 BUSY with HSEL=1, 2 NONSEQ with HSEL=0
  typedef struct {
    int          kind;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [1:0]  trans;
  } item_t;

  int          n_checks = 0;
  int          n_pass = 0;
  item_t       items[$];
  logic [31:0] rd_q[$];
  logic [31:0] exp_rd[$];
  int          wait_q[$];
  int          resp_bad, idle_bad, data_cycles, n_xfer;
  logic [31:0] model[int];

  function automatic int mkey(logic [31:0] a);
    return int'((a - Base) >> 2) + (ws3 ? 4096 : 0);
  endfunction

  function automatic void model_write(logic [31:0] a, logic [2:0] sz, logic [31:0] d);
    int          k = mkey(a);
    int          sh = 8 * int'(a[1:0]);
    logic [31:0] w = model.exists(k) ? model[k] : 32'h0;
    if (sz == 3'd0) w[sh +: 8] = d[sh +: 8];
    else if (sz == 3'd1) w[sh +: 16] = d[sh +: 16];
    else w = d;
    model[k] = w;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a);
    int k = mkey(a);
    return model.exists(k) ? model[k] : 32'h0;
  endfunction

  function automatic void add_item(int kind, logic wr, logic [31:0] a, logic [2:0] sz,
                                   logic [31:0] d, logic [1:0] tr);
    item_t it;
    it.kind = kind; it.wr = wr; it.addr = a; it.size = sz; it.wdata = d; it.trans = tr;
    items.push_back(it);
  endfunction

  // Sequential memory semantics: every transfer sees all earlier writes.
  function automatic void replay();
    exp_rd.delete();
    n_xfer = 0;
    foreach (items[k]) begin
      if (items[k].kind == 0) begin
        n_xfer++;
        if (items[k].wr) model_write(items[k].addr, items[k].size, items[k].wdata);
        else exp_rd.push_back(model_read(items[k].addr));
      end
    end
  endfunction

  // Pipelined AHB master; entered and left 1 time unit after a rising edge.
  task automatic run_items();
    int    i = 0;
    int    w = 0;
    int    cyc = 0;
    bit    pend = 0;
    item_t p;
    rd_q.delete(); wait_q.delete();
    resp_bad = 0; idle_bad = 0; data_cycles = 0;
    while ((i < items.size() || pend) && cyc < 2000) begin
      if (i < items.size()) begin
        hsel   = (items[i].kind != 2);
        HTRANS = (items[i].kind == 1) ? TransBusy : items[i].trans;
        HADDR  = items[i].addr;
        HWRITE = items[i].wr;
        HSIZE  = items[i].size;
      end else begin
        hsel = 1'b0; HTRANS = TransIdle;
      end
      HWDATA = (pend && p.wr) ? p.wdata : 32'h0;
      @(negedge HCLK);
      if (pend) begin
        data_cycles++;
        if (bus_resp !== RespOkay) resp_bad++;
        if (!bus_ready) w++;
        else begin
          wait_q.push_back(w);
          if (!p.wr) rd_q.push_back(bus_rdata);
        end
      end else if (bus_ready !== 1'b1 || bus_resp !== RespOkay) begin
        idle_bad++;
      end
      if (bus_ready) begin
        pend = 0;
        if (i < items.size()) begin
          if (items[i].kind == 0) begin pend = 1; p = items[i]; w = 0; end
          i++;
        end
      end
      @(posedge HCLK); #1;
      cyc++;
    end
    if (cyc >= 2000) begin
      n_checks++;
      $display("FAIL engine_timeout: cycles=%0d limit=2000", cyc);
    end
    hsel = 1'b0; HTRANS = TransIdle;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    n_checks++; if (rdy0 !== 1'b1) $display("FAIL reset_ready0: got %b want 1", rdy0); else n_pass++;
    n_checks++; if (rdy3 !== 1'b1) $display("FAIL reset_ready3: got %b want 1", rdy3); else n_pass++;
    n_checks++; if (resp0 !== RespOkay) $display("FAIL reset_resp0: got %0d want 0", resp0); else n_pass++;
    n_checks++; if (resp3 !== RespOkay) $display("FAIL reset_resp3: got %0d want 0", resp3); else n_pass++;
    n_checks++; if (rdata0 !== 32'h0) $display("FAIL reset_rdata0: got %h want 0", rdata0); else n_pass++;
    n_checks++; if (rdata3 !== 32'h0) $display("FAIL reset_rdata3: got %h want 0", rdata3); else n_pass++;
    @(posedge HCLK); #1;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    ws3 = 1'b0;
    items.delete();
    add_item(0, 1'b1, Base, SizeBits32, 32'hDEAD_BEEF, TransNonseq);
    add_item(0, 1'b0, Base, SizeBits32, 32'h0, TransNonseq);
    replay(); run_items();
    foreach (wait_q[k]) if (wait_q[k] != 0) bad++;
    n_checks++; if (rd_q.size() !== 1) $display("FAIL b2b_count: got %0d want 1", rd_q.size()); else n_pass++;
    n_checks++; if (rd_q.size() == 0 || rd_q[0] !== 32'hDEAD_BEEF)
      $display("FAIL b2b_data: got %h want deadbeef", rd_q.size() ? rd_q[0] : 32'hx); else n_pass++;
    n_checks++; if (data_cycles !== 2) $display("FAIL b2b_cycles: got %0d want 2", data_cycles); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL b2b_ready_low: got %0d beats want 0", bad); else n_pass++;
    n_checks++; if (resp_bad !== 0) $display("FAIL b2b_resp: got %0d bad want 0", resp_bad); else n_pass++;
  endtask

  task automatic test_byte_write();
    ws3 = 1'b0;
    items.delete();
    add_item(0, 1'b1, Base + 32'h4, SizeBits32, 32'h1111_1111, TransNonseq);
    add_item(0, 1'b1, Base + 32'h6, SizeBits8, {4{8'hA5}}, TransNonseq);
    add_item(0, 1'b0, Base + 32'h4, SizeBits32, 32'h0, TransNonseq);
    add_item(0, 1'b1, Base + 32'h4, SizeBits16, 32'h1234_BEEF, TransNonseq);
    add_item(0, 1'b0, Base + 32'h4, SizeBits32, 32'h0, TransNonseq);
    replay(); run_items();
    n_checks++; if (rd_q.size() !== 2) $display("FAIL byte_count: got %0d want 2", rd_q.size()); else n_pass++;
    n_checks++; if (rd_q.size() < 1 || rd_q[0] !== 32'h11A5_1111)
      $display("FAIL byte_lane: got %h want 11a51111", rd_q.size() ? rd_q[0] : 32'hx); else n_pass++;
    n_checks++; if (rd_q.size() < 2 || rd_q[1] !== exp_rd[1])
      $display("FAIL half_lane: got %h want %h", rd_q.size() > 1 ? rd_q[1] : 32'hx, exp_rd[1]); else n_pass++;
  endtask

  task automatic test_incr_wait();
    int bad = 0;
    ws3 = 1'b1;
    items.delete();
    for (int n = 0; n < 8; n++) add_item(0, 1'b1, Base + 32'h10 + 4 * n, SizeBits32, n, TransNonseq);
    replay(); run_items();
    items.delete();
    HBURST = BurstIncr;
    for (int n = 0; n < 8; n++)
      add_item(0, 1'b0, Base + 32'h10 + 4 * n, SizeBits32, 32'h0, n == 0 ? TransNonseq : TransSeq);
    replay(); run_items();
    HBURST = BurstSingle;
    foreach (wait_q[k]) if (wait_q[k] != 3) bad++;
    n_checks++; if (rd_q.size() !== 8) $display("FAIL incr_count: got %0d want 8", rd_q.size()); else n_pass++;
    for (int n = 0; n < 8; n++) begin
      logic [31:0] got = (n < rd_q.size()) ? rd_q[n] : 32'hx;
      n_checks++; if (got !== 32'(n)) $display("FAIL incr_beat%0d: got %h want %h", n, got, n); else n_pass++;
    end
    n_checks++; if (bad !== 0) $display("FAIL incr_waits: got %0d beats off want 0", bad); else n_pass++;
    n_checks++; if (data_cycles !== 32) $display("FAIL incr_cycles: got %0d want 32", data_cycles); else n_pass++;
  endtask

  task automatic test_busy_hsel();
    for (int w = 0; w < 2; w++) begin
      ws3 = w[0];
      items.delete();
      for (int n = 0; n < 4; n++) add_item(0, 1'b1, Base + 32'h80 + 4 * n, SizeBits32, $urandom, TransNonseq);
      replay(); run_items();
      items.delete();
      HBURST = BurstIncr4;
      add_item(0, 1'b0, Base + 32'h80, SizeBits32, 0, TransNonseq);
      add_item(1, 1'b1, Base + 32'h88, SizeBits32, 0, TransBusy);
      add_item(0, 1'b0, Base + 32'h84, SizeBits32, 0, TransSeq);
      add_item(2, 1'b1, Base + 32'h88, SizeBits32, 0, TransNonseq);
      add_item(2, 1'b1, Base + 32'h88, SizeBits32, 0, TransNonseq);
      add_item(0, 1'b0, Base + 32'h88, SizeBits32, 0, TransSeq);
      add_item(1, 1'b1, Base + 32'h8C, SizeBits32, 0, TransBusy);
      add_item(1, 1'b1, Base + 32'h8C, SizeBits32, 0, TransBusy);
      add_item(0, 1'b0, Base + 32'h8C, SizeBits32, 0, TransSeq);
      replay(); run_items();
      HBURST = BurstSingle;
      foreach (exp_rd[k]) begin
        logic [31:0] got = (k < rd_q.size()) ? rd_q[k] : 32'hx;
        n_checks++; if (got !== exp_rd[k]) $display("FAIL busy_ws%0d_beat%0d: got %h want %h", w * 3, k, got, exp_rd[k]); else n_pass++;
      end
      n_checks++; if (idle_bad !== 0) $display("FAIL busy_ws%0d_idle: got %0d bad cycles want 0", w * 3, idle_bad); else n_pass++;
    end
  endtask

  task automatic test_error();
    logic [31:0] a;
    logic [2:0]  sz;
    logic        wr;
    for (int w = 0; w < 2; w++) begin
      ws3 = w[0];
      items.delete();
      add_item(0, 1'b1, Base, SizeBits32, $urandom, TransNonseq);
      add_item(0, 1'b1, Base + 32'hFFC, SizeBits32, $urandom, TransNonseq);
      replay(); run_items();
    end
    for (int e = 0; e < 5; e++) begin
      case (e)
        0:       begin a = Base + 32'h1000; sz = SizeBits32; wr = 1'b0; end
        1:       begin a = Base + 32'h2;    sz = SizeBits32; wr = 1'b1; end
        2:       begin a = Base + 32'h1;    sz = SizeBits16; wr = 1'b1; end
        3:       begin a = Base;            sz = SizeBits64; wr = 1'b1; end
        default: begin a = Base - 32'h4;    sz = SizeBits32; wr = 1'b1; end
      endcase
      ws3 = e[0];
      hsel = 1'b1; HTRANS = TransNonseq; HADDR = a; HWRITE = wr; HSIZE = sz;
      @(posedge HCLK); #1;
      hsel = 1'b0; HTRANS = TransIdle; HWDATA = $urandom;
      @(negedge HCLK);
      n_checks++; if (bus_ready !== 1'b0) $display("FAIL err%0d_c1_ready: got %b want 0", e, bus_ready); else n_pass++;
      n_checks++; if (bus_resp !== RespError) $display("FAIL err%0d_c1_resp: got %0d want 1", e, bus_resp); else n_pass++;
      @(posedge HCLK); #1;
      @(negedge HCLK);
      n_checks++; if (bus_ready !== 1'b1) $display("FAIL err%0d_c2_ready: got %b want 1", e, bus_ready); else n_pass++;
      n_checks++; if (bus_resp !== RespError) $display("FAIL err%0d_c2_resp: got %0d want 1", e, bus_resp); else n_pass++;
      @(posedge HCLK); #1;
      @(negedge HCLK);
      n_checks++; if (bus_resp !== RespOkay) $display("FAIL err%0d_after_resp: got %0d want 0", e, bus_resp); else n_pass++;
      @(posedge HCLK); #1;
    end
    for (int w = 0; w < 2; w++) begin
      ws3 = w[0];
      items.delete();
      add_item(0, 1'b0, Base, SizeBits32, 0, TransNonseq);
      add_item(0, 1'b0, Base + 32'hFFC, SizeBits32, 0, TransNonseq);
      replay(); run_items();
      foreach (exp_rd[k]) begin
        logic [31:0] got = (k < rd_q.size()) ? rd_q[k] : 32'hx;
        n_checks++; if (got !== exp_rd[k]) $display("FAIL err_ws%0d_ram%0d: got %h want %h", w * 3, k, got, exp_rd[k]); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] old = $urandom;
    ws3 = 1'b1;
    items.delete();
    add_item(0, 1'b1, Base + 32'h40, SizeBits32, old, TransNonseq);
    replay(); run_items();
    hsel = 1'b1; HTRANS = TransNonseq; HADDR = Base + 32'h40; HWRITE = 1'b1; HSIZE = SizeBits32;
    @(posedge HCLK); #1;
    hsel = 1'b0; HTRANS = TransIdle; HWDATA = ~old;
    @(negedge HCLK);
    n_checks++; if (bus_ready !== 1'b0) $display("FAIL rst_wait1_ready: got %b want 0", bus_ready); else n_pass++;
    @(posedge HCLK); #1 HRESET = 1'b1;
    @(posedge HCLK); #1 HRESET = 1'b0;
    @(negedge HCLK);
    n_checks++; if (bus_ready !== 1'b1) $display("FAIL rst_after_ready: got %b want 1", bus_ready); else n_pass++;
    n_checks++; if (bus_resp !== RespOkay) $display("FAIL rst_after_resp: got %0d want 0", bus_resp); else n_pass++;
    @(posedge HCLK); #1;
    @(negedge HCLK);
    n_checks++; if (bus_ready !== 1'b1) $display("FAIL rst_idle_ready: got %b want 1", bus_ready); else n_pass++;
    @(posedge HCLK); #1;
    items.delete();
    add_item(0, 1'b0, Base + 32'h40, SizeBits32, 0, TransNonseq);
    replay(); run_items();
    n_checks++; if (rd_q.size() == 0 || rd_q[0] !== old)
      $display("FAIL rst_word_kept: got %h want %h", rd_q.size() ? rd_q[0] : 32'hx, old); else n_pass++;
  endtask

  task automatic test_random_mix();
    logic [31:0] a;
    int          sz, r, bad;
    for (int w = 0; w < 2; w++) begin
      ws3 = w[0];
      items.delete();
      for (int k = 0; k < 16; k++) add_item(0, 1'b1, Base + 32'h100 + 4 * k, SizeBits32, $urandom, TransNonseq);
      for (int k = 0; k < 40; k++) begin
        r = $urandom_range(0, 9);
        if (r == 0) add_item(1, 1'b1, Base + 32'h100, SizeBits32, 0, TransBusy);
        else if (r == 1) add_item(2, 1'b1, Base + 32'h104, SizeBits32, 0, TransNonseq);
        else begin
          sz = $urandom_range(0, 2);
          a  = Base + 32'h100 + 4 * $urandom_range(0, 15);
          if (sz == 0) a += $urandom_range(0, 3);
          else if (sz == 1) a += 2 * $urandom_range(0, 1);
          add_item(0, 1'($urandom_range(0, 1)), a, 3'(sz), $urandom, TransNonseq);
        end
      end
      replay(); run_items();
      bad = 0;
      foreach (wait_q[k]) if (wait_q[k] != 3 * w) bad++;
      foreach (exp_rd[k]) begin
        logic [31:0] got = (k < rd_q.size()) ? rd_q[k] : 32'hx;
        n_checks++; if (got !== exp_rd[k]) $display("FAIL rand_ws%0d_rd%0d: got %h want %h", w * 3, k, got, exp_rd[k]); else n_pass++;
      end
      n_checks++; if (wait_q.size() !== n_xfer) $display("FAIL rand_ws%0d_beats: got %0d want %0d", w * 3, wait_q.size(), n_xfer); else n_pass++;
      n_checks++; if (bad !== 0) $display("FAIL rand_ws%0d_waits: got %0d beats off want 0", w * 3, bad); else n_pass++;
      n_checks++; if (resp_bad !== 0) $display("FAIL rand_ws%0d_resp: got %0d bad want 0", w * 3, resp_bad); else n_pass++;
      n_checks++; if (idle_bad !== 0) $display("FAIL rand_ws%0d_idle: got %0d bad want 0", w * 3, idle_bad); else n_pass++;
    end
  endtask

  initial begin
    HRESET = 1'b1; hsel = 1'b0; HTRANS = TransIdle; HADDR = '0; HWRITE = 1'b0;
    HSIZE = SizeBits32; HBURST = BurstSingle; HWDATA = '0; ws3 = 1'b0;
    test_reset();
    test_back_to_back();
    test_byte_write();
    test_incr_wait();
    test_busy_hsel();
    test_error();
    test_reset_mid_write();
    test_random_mix();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
